// File: rtl/nios_system_nios2_qsys_0_mul_seq.sv
// nios_system_nios2_qsys_0_mul_seq
// Two-pass multiply sequencer in front of the 32x16 multiply cell. The low
// and high halves of operand 2 are fed to the cell on consecutive cycles and
// the two partial products are recombined into the low 32 bits of the full
// 32x32 product (identical for signed and unsigned operands).
//
// Optional build macro: NIOS_MUL_SEQ_FASTPATH_EN
//   When defined, an operation whose multiplier has a zero upper half skips
//   the second pass and completes one cycle earlier.
module nios_system_nios2_qsys_0_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result
);

  // Cycle on which the low partial product appears at the cell output, and
  // the following cycle on which the high partial product appears.
  localparam logic [2:0] LAT_LO = 3'(CELL_LATENCY);
  localparam logic [2:0] LAT_HI = 3'(CELL_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RSP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [31:0] r_aQ;
  logic [31:0] r_bQ;
  logic [31:0] r_loQ;
  logic [2:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_capLo;
  logic        w_finish;
  logic        w_fastDone;

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode, handshake outputs and datapath strobes.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_capLo     = 1'b0;
    w_finish    = 1'b0;
    w_fastDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAT_LO) begin
          w_capLo = 1'b1;
`ifdef NIOS_MUL_SEQ_FASTPATH_EN
          if (r_bQ[31:16] == 16'h0) begin
            w_fastDone  = 1'b1;
            w_nextState = ST_RSP;
          end
`endif
        end
        if (r_cnt == LAT_HI) begin
          w_finish    = 1'b1;
          w_nextState = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            w_accept    = 1'b1;
            w_nextState = ST_RUN;
          end else begin
            w_nextState = ST_IDLE;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Operand latches and pass counter; the counter restarts on every accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aQ  <= '0;
      r_bQ  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_aQ  <= req_src1;
      r_bQ  <= req_src2;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Partial-product capture and result recombination (carry out of bit 31 is dropped).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loQ    <= '0;
      r_result <= '0;
    end else begin
      if (w_capLo) begin
        r_loQ <= A_mul_cell_result;
      end
      if (w_fastDone) begin
        r_result <= A_mul_cell_result;
      end else if (w_finish) begin
        r_result <= r_loQ + {A_mul_cell_result[15:0], 16'h0};
      end
    end
  end

  // Cell operands are muxed only from registered state, and held at zero outside RUN.
  always_comb begin
    A_mul_src1 = '0;
    A_mul_src2 = '0;
    if (r_state == ST_RUN) begin
      A_mul_src1 = r_aQ;
      A_mul_src2 = (r_cnt == 3'd0) ? {16'h0, r_bQ[15:0]} : {16'h0, r_bQ[31:16]};
    end
  end

  assign rsp_result = r_result;

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_mul_seq.sv
// Testbench for nios_system_nios2_qsys_0_mul_seq: two sequencer instances
// (cell latency 1 and 2), each driving a behavioural multiply cell.
module tb_nios_system_nios2_qsys_0_mul_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  // Latency-1 instance signals
  logic        reqValid, reqReady, rspValid, rspReady;
  logic [31:0] reqSrc1, reqSrc2, rspResult, mulSrc1, mulSrc2, cellResult;

  // Latency-2 instance signals
  logic        reqValid2, reqReady2, rspValid2, rspReady2;
  logic [31:0] reqSrc1b, reqSrc2b, rspResult2, mulSrc1b, mulSrc2b, cellResult2;
  logic [31:0] cell2Stage1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [8];

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  nios_system_nios2_qsys_0_mul_seq #(.CELL_LATENCY(1)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (reqValid),
    .req_ready         (reqReady),
    .req_src1          (reqSrc1),
    .req_src2          (reqSrc2),
    .rsp_valid         (rspValid),
    .rsp_ready         (rspReady),
    .rsp_result        (rspResult),
    .A_mul_src1        (mulSrc1),
    .A_mul_src2        (mulSrc2),
    .A_mul_cell_result (cellResult)
  );

  nios_system_nios2_qsys_0_mul_seq #(.CELL_LATENCY(2)) dut2 (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (reqValid2),
    .req_ready         (reqReady2),
    .req_src1          (reqSrc1b),
    .req_src2          (reqSrc2b),
    .rsp_valid         (rspValid2),
    .rsp_ready         (rspReady2),
    .rsp_result        (rspResult2),
    .A_mul_src1        (mulSrc1b),
    .A_mul_src2        (mulSrc2b),
    .A_mul_cell_result (cellResult2)
  );

  // Low 32 bits of a * b[15:0], which is all the real cell computes
  function automatic logic [31:0] cellMul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {48'h0, b[15:0]};
    return p[31:0];
  endfunction

  // Expected accept-to-valid latency for a given cell latency and multiplier
  function automatic int expLat(input int lat, input logic [31:0] b);
    logic fast;
    fast = 1'b0;
`ifdef NIOS_MUL_SEQ_FASTPATH_EN
    fast = 1'b1;
`endif
    return (fast && (b[31:16] == 16'h0)) ? lat + 1 : lat + 2;
  endfunction

  // Single-stage cell model with asynchronous clear
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cellResult <= '0;
    else          cellResult <= cellMul(mulSrc1, mulSrc2);
  end

  // Two-stage cell model with asynchronous clear
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell2Stage1 <= '0;
      cellResult2 <= '0;
    end else begin
      cell2Stage1 <= cellMul(mulSrc1b, mulSrc2b);
      cellResult2 <= cell2Stage1;
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passes);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full transaction on the latency-1 instance, checking latency and result
  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expected);
    int n;
    @(negedge clk);
    n = 0;
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    reqValid = 1'b1;
    reqSrc1  = a;
    reqSrc2  = b;
    checkOutput({name, " req_ready"}, 32'(reqReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reqSrc1  = 32'hA5A5A5A5;
    reqSrc2  = 32'h5A5A5A5A;
    n = 0;
    while (!rspValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " latency"}, 32'(n), 32'(expLat(1, b)));
    checkOutput({name, " result"}, rspResult, expected);
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput({name, " rsp_valid drop"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    int n;
    logic sawValid;

    vecs[0] = '{32'h00000003, 32'h00000005, 32'h0000000F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2] = '{32'h12345678, 32'h00010000, 32'h56780000};
    vecs[3] = '{32'h00010001, 32'h00010001, 32'h00020001};
    vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    vecs[5] = '{32'h80000000, 32'h00000002, 32'h00000000};
    vecs[6] = '{32'h00001234, 32'h00050000, 32'h5B040000};
    vecs[7] = '{32'h12345678, 32'hFFFFFFFF, 32'hEDCBA988};

    reqValid  = 1'b0; reqSrc1  = '0; reqSrc2  = '0; rspReady  = 1'b0;
    reqValid2 = 1'b0; reqSrc1b = '0; reqSrc2b = '0; rspReady2 = 1'b0;

    // Power-on reset
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset rsp_result", rspResult, 32'd0);
    checkOutput("reset A_mul_src1", mulSrc1, 32'd0);
    checkOutput("reset A_mul_src2", mulSrc2, 32'd0);
    checkOutput("reset req_ready lat2", 32'(reqReady2), 32'd1);
    reset_n = 1'b1;

    // Table-driven products
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    // Backpressure: result held while the next request waits
    @(negedge clk);
    reqValid = 1'b1; reqSrc1 = 32'h00010001; reqSrc2 = 32'h00010001;
    @(posedge clk);
    @(negedge clk);
    reqSrc1 = 32'h12345678; reqSrc2 = 32'h00010000;
    n = 0;
    while (!rspValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp hold%0d rsp_valid", i), 32'(rspValid), 32'd1);
      checkOutput($sformatf("bp hold%0d rsp_result", i), rspResult, 32'h00020001);
      checkOutput($sformatf("bp hold%0d req_ready", i), 32'(reqReady), 32'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    #1;
    checkOutput("bp release req_ready", 32'(reqReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0; reqValid = 1'b0;
    checkOutput("bp next rsp_valid low", 32'(rspValid), 32'd0);
    n = 0;
    while (!rspValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp next latency", 32'(n), 32'd3);
    checkOutput("bp next result", rspResult, 32'h56780000);
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;

    // Reset in the middle of an operation
    reqValid = 1'b1; reqSrc1 = 32'h11112222; reqSrc2 = 32'h33334444;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("run cnt0 A_mul_src1", mulSrc1, 32'h11112222);
    checkOutput("run cnt0 A_mul_src2", mulSrc2, 32'h00004444);
    @(negedge clk);
    checkOutput("run cnt1 A_mul_src2", mulSrc2, 32'h00003333);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("midreset rsp_result", rspResult, 32'd0);
    checkOutput("midreset A_mul_src1", mulSrc1, 32'd0);
    checkOutput("midreset A_mul_src2", mulSrc2, 32'd0);
    checkOutput("midreset req_ready", 32'(reqReady), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rspValid) sawValid = 1'b1;
    end
    checkOutput("midreset no response", 32'(sawValid), 32'd0);
    applyStimulus("after reset 7*9", 32'd7, 32'd9, 32'h0000003F);

    // Two-stage cell: short and full-length multipliers
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a2, b2, e2;
      a2 = (k == 0) ? 32'hDEADBEEF : 32'h12345678;
      b2 = (k == 0) ? 32'h00000002 : 32'hFFFFFFFF;
      e2 = (k == 0) ? 32'hBD5B7DDE : 32'hEDCBA988;
      @(negedge clk);
      reqValid2 = 1'b1; reqSrc1b = a2; reqSrc2b = b2;
      checkOutput($sformatf("lat2 op%0d req_ready", k), 32'(reqReady2), 32'd1);
      @(posedge clk);
      @(negedge clk);
      reqValid2 = 1'b0;
      n = 0;
      while (!rspValid2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("lat2 op%0d latency", k), 32'(n), 32'(expLat(2, b2)));
      checkOutput($sformatf("lat2 op%0d result", k), rspResult2, e2);
      rspReady2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rspReady2 = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
